muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle multiply/divide controller beside the EX-stage ALU; owns the HI/LO registers.
//  Accepts MULT/MULTU/DIV/DIVU from EX and runs one shift-add/restoring-divide step per cycle.
//  Holds the pipeline through stall_o until the HI/LO result is committed.
//  Also services MTHI/MTLO writes from EX.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      synchronous, active-low reset
//  start     in   1      EX holds a mul/div op (level, held while stalled)
//  op        in   2      0=MULT 1=MULTU 2=DIV 3=DIVU (sampled with start)
//  opa       in   WIDTH  multiplicand / dividend (rs)
//  opb       in   WIDTH  multiplier / divisor (rt)
//  flush     in   1      abort in-flight op (branch/exception squash)
//  hi_we     in   1      MTHI write enable
//  lo_we     in   1      MTLO write enable
//  wdata     in   WIDTH  MTHI/MTLO data
//  busy_o    out  1      state != IDLE
//  stall_o   out  1      comb: busy_o | (accept condition true this cycle)
//  done_o    out  1      registered one-cycle pulse; HI/LO valid this cycle
//  hi_o      out  WIDTH  HI register
//  lo_o      out  WIDTH  LO register
// BEHAVIOUR
//  Reset (rst==0 at edge): state=IDLE, cnt=0, hi_o=lo_o=0, done_o=0, busy_o=0. Wins over all.
//  States: IDLE -> CALC -> FIX -> IDLE.
//  Accept: in IDLE with start=1, done_o=0, flush=0. Latch op; latch |opa|, |opb| for signed ops, raw otherwise.
//   Latch sign flags. Go to CALC, cnt=0.
//  done_o=1 blocks accept: the held start of a finished op cannot retrigger. Next op is accepted a cycle later.
//  CALC: one iteration per cycle, cnt++. Leave after cnt==WIDTH-1, i.e. exactly WIDTH cycles.
//   Mul: 2*WIDTH-bit shift-add, unsigned magnitudes.
//   Div: restoring; WIDTH+1-bit partial remainder; quotient bit shifted in per step.
//  FIX (1 cycle): sign correction.
//   Mul: negate the 64-bit product if signs differ.
//   Div: negate the quotient if signs differ; the remainder takes the dividend's sign.
//   Same edge: commit HI/LO, set done_o=1, go to IDLE.
//   Mul result: HI=product[2W-1:W], LO=product[W-1:0]. Div result: LO=quotient, HI=remainder.
//  Latency: start accepted at edge E0; busy_o=1 for cycles 1..WIDTH+1; done_o=1 in cycle WIDTH+2 (34 for W=32).
//  Divide by zero: same latency; HI=opa (raw), LO=all ones; no sign fixup.
//  Overflow DIV 0x80000000/-1: LO=0x80000000 (wraps), HI=0.
//  flush=1 in any state (not reset): go to IDLE, cnt=0, done_o=0, HI/LO untouched. Priority over start.
//  MTHI/MTLO:
//   hi_we/lo_we apply at the edge only when state==IDLE and flush=0; HI<=wdata / LO<=wdata.
//   Ignored while busy_o=1 (cannot occur in a correct pipeline).
//   A write in the done_o cycle is applied and overrides the just-committed value.
//  hi_o/lo_o change only on commit, MTHI/MTLO, or reset.
// TESTING
//  MULTU 3*5: start at c0 -> busy c1..c33, done c34, HI=0, LO=15; start held through c34 -> one op only.
//  MULT -2*3: HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULT 0x80000000*0x80000000: HI=0x40000000, LO=0.
//  DIV -7/2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  DIVU 0xFFFFFFFF/0x10: LO=0x0FFFFFFF, HI=0xF.
//  DIVU 7/0: HI=7, LO=0xFFFFFFFF at c34. DIV 0x80000000/-1: LO=0x80000000, HI=0.
//  flush at c10 of a MULTU -> busy 0 at c11, HI/LO unchanged, no done. New start c12 -> done c46.
//  rst low at c20 mid-DIV -> all outputs 0 next cycle. hi_we+wdata=0xA5 in IDLE -> hi_o=0xA5 next cycle.

Source files
------------

// File: rtl/muldiv_if.sv
// EX-stage <-> multiply/divide sequencer link: op issue, flush, MTHI/MTLO writes and HI/LO readback.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy_o;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start, op, opa, opb, flush, hi_we, lo_we, wdata,
        input  busy_o, stall_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start, op, opa, opb, flush, hi_we, lo_we, wdata,
        output busy_o, stall_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one shift-add or restoring-divide step per cycle,
// sign fix-up and commit in a final cycle, plus MTHI/MTLO writes while idle.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);
    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned      PROD_W   = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_div_q, is_div_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic                done_q, done_d;

    logic                accept_c;
    logic                signed_c;
    logic                sa_c;
    logic                sb_c;
    logic [WIDTH-1:0]    mag_a_c;
    logic [WIDTH-1:0]    mag_b_c;
    logic [WIDTH:0]      add_c;
    logic [WIDTH:0]      shl_c;
    logic [WIDTH:0]      sub_c;
    logic [PROD_W-1:0]   prod_fix_c;
    logic [WIDTH-1:0]    quo_fix_c;
    logic [WIDTH-1:0]    rem_fix_c;

    // Operand magnitudes; ops 0 and 2 are the signed ones.
    assign signed_c = ~bus.op[0];
    assign sa_c     = signed_c & bus.opa[WIDTH-1];
    assign sb_c     = signed_c & bus.opb[WIDTH-1];
    assign mag_a_c  = sa_c ? (WIDTH'(0) - bus.opa) : bus.opa;
    assign mag_b_c  = sb_c ? (WIDTH'(0) - bus.opb) : bus.opb;

    // A finished op's still-held start is blocked by done_q for one cycle.
    assign accept_c = (state_q == S_IDLE) & bus.start & ~done_q & ~bus.flush;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign add_c = {1'b0, acc_q[PROD_W-1:WIDTH]} + {1'b0, opnd_q};
    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    assign shl_c = {acc_q[PROD_W-1:WIDTH], acc_q[WIDTH-1]};
    assign sub_c = shl_c - {1'b0, opnd_q};

    assign prod_fix_c = neg_res_q ? (PROD_W'(0) - acc_q) : acc_q;
    assign quo_fix_c  = neg_res_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    assign rem_fix_c  = neg_rem_q ? (WIDTH'(0) - acc_q[PROD_W-1:WIDTH]) : acc_q[PROD_W-1:WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush aborts from any state.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept_c) state_d = S_CALC;
                S_CALC:  if (cnt_q == CNT_LAST) state_d = S_FIX;
                S_FIX:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        bus.busy_o  = (state_q != S_IDLE);
        bus.stall_o = (state_q != S_IDLE) | accept_c;
        bus.done_o  = done_q;
        bus.hi_o    = hi_q;
        bus.lo_o    = lo_q;
    end

    // Datapath next values.
    always_comb begin
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        if (bus.flush) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        cnt_d    = '0;
                        is_div_d = bus.op[1];
                        if (bus.op[1]) begin
                            // A zero divisor keeps the all-ones quotient unnegated.
                            opnd_d    = mag_b_c;
                            acc_d     = {WIDTH'(0), mag_a_c};
                            neg_res_d = (sa_c ^ sb_c) & (|bus.opb);
                            neg_rem_d = sa_c;
                        end else begin
                            opnd_d    = mag_a_c;
                            acc_d     = {WIDTH'(0), mag_b_c};
                            neg_res_d = sa_c ^ sb_c;
                            neg_rem_d = 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_div_q) begin
                        if (!sub_c[WIDTH]) begin
                            acc_d = {sub_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {shl_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                        end
                    end else if (acc_q[0]) begin
                        acc_d = {add_c, acc_q[WIDTH-1:1]};
                    end else begin
                        acc_d = {1'b0, acc_q[PROD_W-1:1]};
                    end
                end
                S_FIX: begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    if (is_div_q) begin
                        lo_d = quo_fix_c;
                        hi_d = rem_fix_c;
                    end else begin
                        hi_d = prod_fix_c[PROD_W-1:WIDTH];
                        lo_d = prod_fix_c[WIDTH-1:0];
                    end
                end
                default: cnt_d = '0;
            endcase
            // MTHI/MTLO land only while idle, including the done cycle.
            if (state_q == S_IDLE) begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: table of arithmetic vectors plus flush, reset and MTHI/MTLO sequences.
module tb_muldiv_sequencer;
    localparam int unsigned W = 32;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   lat;
    vec_t vecs[11];

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; returns at the falling edge, where outputs are sampled and inputs driven.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        bus.start = 1'b1;
        #1;
        check("stall on accept", W'(bus.stall_o), W'(1));
        tick();
        check("busy after accept", W'(bus.busy_o), W'(1));
    endtask

    // Cycles from the accept edge until done_o, bounded.
    task automatic wait_done(output int cycles);
        cycles = 1;
        while (bus.done_o !== 1'b1 && cycles < 60) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        vecs[0]  = '{2'd1, 32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F, "MULTU 3*5"};
        vecs[1]  = '{2'd0, 32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF, 32'hFFFF_FFFA, "MULT -2*3"};
        vecs[2]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "MULT min*min"};
        vecs[3]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "MULTU max*max"};
        vecs[4]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "MULT -1*-1"};
        vecs[5]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD, "DIV -7/2"};
        vecs[6]  = '{2'd2, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "DIV 7/-2"};
        vecs[7]  = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, "DIVU max/16"};
        vecs[8]  = '{2'd3, 32'd7,        32'd0,        32'h0000_0007, 32'hFFFF_FFFF, "DIVU 7/0"};
        vecs[9]  = '{2'd2, 32'hFFFF_FFF9, 32'd0,       32'hFFFF_FFF9, 32'hFFFF_FFFF, "DIV -7/0"};
        vecs[10] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "DIV min/-1"};

        rst       = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.opa   = '0;
        bus.opb   = '0;
        bus.flush = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        tick();
        tick();
        rst = 1'b1;
        check("reset busy", W'(bus.busy_o), W'(0));
        check("reset done", W'(bus.done_o), W'(0));
        check("reset stall", W'(bus.stall_o), W'(0));
        check("reset hi", bus.hi_o, W'(0));
        check("reset lo", bus.lo_o, W'(0));

        // Each op starts at c0; start stays held through the done cycle c34.
        for (int i = 0; i < 11; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat);
            check({vecs[i].name, " latency"}, W'(lat), W'(34));
            check({vecs[i].name, " hi"}, bus.hi_o, vecs[i].hi);
            check({vecs[i].name, " lo"}, bus.lo_o, vecs[i].lo);
            check({vecs[i].name, " stall in done"}, W'(bus.stall_o), W'(0));
            tick();
            check({vecs[i].name, " single op"}, W'(bus.busy_o), W'(0));
            check({vecs[i].name, " done pulse"}, W'(bus.done_o), W'(0));
            bus.start = 1'b0;
        end

        // MTLO in the done cycle overrides the fresh result.
        start_op(2'd1, 32'd2, 32'd2);
        wait_done(lat);
        check("override latency", W'(lat), W'(34));
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_1234;
        tick();
        bus.lo_we = 1'b0;
        bus.start = 1'b0;
        check("override lo", bus.lo_o, 32'h0000_1234);
        check("override hi", bus.hi_o, 32'h0000_0000);

        // MTHI / MTLO while idle.
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_00A5;
        tick();
        bus.hi_we = 1'b0;
        check("mthi", bus.hi_o, 32'h0000_00A5);
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_005A;
        tick();
        bus.lo_we = 1'b0;
        check("mtlo", bus.lo_o, 32'h0000_005A);

        // MTHI while busy is dropped; flush then leaves HI/LO alone.
        start_op(2'd1, 32'd3, 32'd5);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_DEAD;
        tick();
        bus.hi_we = 1'b0;
        check("mthi ignored busy", bus.hi_o, 32'h0000_00A5);
        bus.flush = 1'b1;
        bus.start = 1'b0;
        tick();
        bus.flush = 1'b0;
        check("flush early busy", W'(bus.busy_o), W'(0));
        check("flush early hi", bus.hi_o, 32'h0000_00A5);

        // Flush at c10 with start still high: idle at c11, no done, restart at c12 -> done c46.
        start_op(2'd1, 32'd3, 32'd5);
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("flush busy c11", W'(bus.busy_o), W'(0));
        check("flush done c11", W'(bus.done_o), W'(0));
        check("flush hi c11", bus.hi_o, 32'h0000_00A5);
        check("flush lo c11", bus.lo_o, 32'h0000_005A);
        tick();
        start_op(2'd1, 32'd3, 32'd5);
        wait_done(lat);
        check("restart latency", W'(lat), W'(34));
        check("restart hi", bus.hi_o, 32'h0000_0000);
        check("restart lo", bus.lo_o, 32'h0000_000F);
        bus.start = 1'b0;
        tick();

        // Reset asserted at c20 of a DIV clears everything by c21.
        start_op(2'd2, 32'd100, 32'd7);
        repeat (19) tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();
        check("midop reset busy", W'(bus.busy_o), W'(0));
        check("midop reset done", W'(bus.done_o), W'(0));
        check("midop reset lo", bus.lo_o, W'(0));
        check("midop reset hi", bus.hi_o, W'(0));
        rst = 1'b1;
        tick();
        check("post reset busy", W'(bus.busy_o), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
